exe_mdu_stage: RTL and testbench
================================

Name: exe_mdu_stage

Overview:
- Next-generation execute stage: parametrised width, valid/ready handshakes on both sides, and an iterative multiply/divide unit alongside single-cycle ALU ops.
- Sits between DEC (issue side) and MEM/WBK (result side).
- Replaces the fixed two-cycle branch squash with a parametrised flush shadow.
- Supports back-pressure from downstream.

Parameters:
- XLEN, 32, operand/result width; ≥ 8, power of two.
- REG_W, 5, destination register address width.
- FLUSH_SHADOW, 2, cycles after flush_i during which accepted issues are discarded; 0 disables the shadow.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_v_i  in  1  issue valid
- in_rdy_o  out  1  stage can accept issue
- op_i  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 MUL, 8 MULH, 9 MULHU, 10 DIV, 11 DIVU, 12 REM, 13 REMU, 14-15 reserved
- rs1_i  in  XLEN  source operand 1
- rs2_i  in  XLEN  source operand 2
- rd_v_i  in  1  instruction writes rd
- rd_adr_i  in  REG_W  destination address
- flush_i  in  1  synchronous kill of in-flight work
- out_v_q_o  out  1  result valid
- out_rdy_i  in  1  downstream accepts result
- out_data_q_o  out  XLEN  result
- out_rd_v_q_o  out  1  registered rd_v
- out_adr_q_o  out  REG_W  registered rd address
- busy_o  out  1  FSM not IDLE

Behaviour:
- Reset (async, reset_n low): FSM=IDLE; all outputs 0 except in_rdy_o=1; shadow counter 0; iteration counter 0.
- Issue handshake: an issue is accepted on a cycle with in_v_i & in_rdy_o.
- in_rdy_o = (state==IDLE) & (~out_v_q_o | out_rdy_i) & ~flush_i.
- Output handshake: out_v_q_o, out_data_q_o, out_rd_v_q_o and out_adr_q_o hold stable until out_v_q_o & out_rdy_i.
  - On that cycle the output register clears, unless a new result loads the same edge.
- Ops 0-6 and 14-15: result registered at the accept edge; out_v_q_o high in cycle T+1.
  - Reserved ops give result 0.
  - SLT/SLTU give 1 or 0, zero-extended.
  - ADD/SUB wrap modulo 2^XLEN.
- Ops 7-13: FSM moves IDLE→MUL or IDLE→DIV at accept. Operands are converted to magnitudes with sign flags latched.
  - MULH: both operands signed. MULHU: both unsigned. MUL: low XLEN bits of the product.
- MUL state: shift-add for XLEN cycles; 2*XLEN-bit accumulator.
- DIV state: restoring division for XLEN cycles.
- Iteration counter: $clog2(XLEN)+1 bits, counts XLEN-1 down to 0.
- FIX state: 1 cycle; applies sign correction, selects high/low/quotient/remainder, loads the output register, then returns to IDLE.
- Total latency: out_v_q_o high in cycle T+XLEN+2.
- If the output register is still occupied at FIX, the FSM holds in FIX until it frees. busy_o stays high.
- Divide by zero:
  - DIV/DIVU quotient = all ones.
  - REM/REMU = rs1.
- Signed overflow (rs1 = most-negative, rs2 = -1):
  - DIV = rs1.
  - REM = 0.
- flush_i:
  - Forces FSM→IDLE at the next edge.
  - Clears out_v_q_o at the next edge, regardless of out_rdy_i.
  - Loads shadow counter with FLUSH_SHADOW.
- Shadow counter nonzero: issues are still handshaken (in_rdy_o per the equation above), but no result is produced and no FSM entry occurs. Counter decrements each cycle, saturating at 0.
- flush_i while the shadow counter is nonzero: counter reloads.
- flush_i has priority over accept, FIX load and output clear on the same edge.
- Reset mid-operation: immediate return to reset state; no partial result is ever presented.

Optional Feature:
- Macro EXE_MDU_EARLY_OUT_EN.
- Defined:
  - MUL/MULH/MULHU with either operand 0 complete in 1 cycle with result 0.
  - DIV/REM with rs2=0 complete in 1 cycle with the divide-by-zero results.
  - No FSM entry in these cases.
- Undefined: every op 7-13 takes the full XLEN+2 latency, including zero-operand cases.

Test Plan:
- Reset, then ADD rs1=0xFFFFFFFF rs2=1, out_rdy_i=1 → out_v_q_o in cycle T+1; data 0x00000000; rd address echoed.
- MULH rs1=0x80000000 rs2=2 (XLEN=32) → out_v_q_o at T+34; data 0xFFFFFFFF; busy_o high T+1..T+33; in_rdy_o low meanwhile.
- DIV 7 / 0 → 0xFFFFFFFF; REM 7 / 0 → 7; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- out_rdy_i=0 for 5 cycles after a SUB result → output held stable, in_rdy_o=0; releases on the out_rdy_i=1 cycle, and next issue is accepted the same cycle.
- flush_i at cycle T+10 of a DIVU → FSM IDLE, out_v_q_o low. Two following issues (FLUSH_SHADOW=2) are handshaken but produce no result; third issue produces a result.
- With EXE_MDU_EARLY_OUT_EN: MUL 0 × 0x1234 → result 0 at T+1. Without the macro → result 0 at T+34.

Source files
------------

// File: rtl/exe_mdu_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier / restoring divider.
// Optional macro EXE_MDU_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero finish in one cycle.
module exe_mdu_stage #(
  parameter int XLEN         = 32,
  parameter int REG_W        = 5,
  parameter int FLUSH_SHADOW = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_v_i,
  output logic             in_rdy_o,
  input  logic [3:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic             rd_v_i,
  input  logic [REG_W-1:0] rd_adr_i,
  input  logic             flush_i,
  output logic             out_v_q_o,
  input  logic             out_rdy_i,
  output logic [XLEN-1:0]  out_data_q_o,
  output logic             out_rd_v_q_o,
  output logic [REG_W-1:0] out_adr_q_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int SH_W  = (FLUSH_SHADOW > 0) ? $clog2(FLUSH_SHADOW + 1) : 1;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB  = 4'd1,  OP_AND   = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_SLT  = 4'd5,  OP_SLTU  = 4'd6,  OP_MUL  = 4'd7;
  localparam logic [3:0] OP_MULH = 4'd8, OP_MULHU = 4'd9, OP_DIV   = 4'd10, OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REM = 4'd12, OP_REMU = 4'd13;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  // High half of a conditionally negated double-width value: the carry out of ~lo+1 only occurs when lo is zero.
  function automatic logic [XLEN-1:0] cond_neg_hi(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? (~v[2*XLEN-1:XLEN] + XLEN'(v[XLEN-1:0] == '0)) : v[2*XLEN-1:XLEN];
  endfunction

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [SH_W-1:0]     r_shadow;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opnd;
  logic [3:0]          r_op;
  logic                r_neg_q, r_neg_r, r_dz, r_rd_v;
  logic [REG_W-1:0]    r_adr;
  logic                r_out_v, r_out_rd_v;
  logic [XLEN-1:0]     r_out_data;
  logic [REG_W-1:0]    r_out_adr;

  logic                w_accept, w_is_mdu, w_is_mul, w_is_div, w_early;
  logic                w_go_mdu, w_go_alu, w_fix_load, w_sgn_op, w_sa, w_sb;
  logic [XLEN-1:0]     w_mag1, w_mag2, w_alu, w_fix_res;
  logic signed [XLEN-1:0] w_rs1_s, w_rs2_s;
  logic [XLEN:0]       w_mul_sum, w_rem_sh, w_diff;
  logic [2*XLEN-1:0]   w_mul_nxt, w_div_nxt;

  assign in_rdy_o   = (r_state == S_IDLE) & (~r_out_v | out_rdy_i) & ~flush_i;
  assign w_accept   = in_v_i & in_rdy_o;
  assign w_is_mdu   = (op_i >= OP_MUL) && (op_i <= OP_REMU);
  assign w_is_mul   = (op_i == OP_MUL) | (op_i == OP_MULH) | (op_i == OP_MULHU);
  assign w_is_div   = w_is_mdu & ~w_is_mul;

`ifdef EXE_MDU_EARLY_OUT_EN
  assign w_early = (w_is_mul & ((rs1_i == '0) | (rs2_i == '0))) | (w_is_div & (rs2_i == '0));
`else
  assign w_early = 1'b0;
`endif

  // Issues landing inside the flush shadow are consumed without effect.
  assign w_go_mdu   = w_accept & (r_shadow == '0) & w_is_mdu & ~w_early;
  assign w_go_alu   = w_accept & (r_shadow == '0) & (~w_is_mdu | w_early);
  assign w_fix_load = (r_state == S_FIX) & (~r_out_v | out_rdy_i) & ~flush_i;

  assign w_sgn_op = (op_i == OP_MULH) | (op_i == OP_DIV) | (op_i == OP_REM);
  assign w_sa     = w_sgn_op & rs1_i[XLEN-1];
  assign w_sb     = w_sgn_op & rs2_i[XLEN-1];
  assign w_mag1   = cond_neg(w_sa, rs1_i);
  assign w_mag2   = cond_neg(w_sb, rs2_i);
  assign w_rs1_s  = rs1_i;
  assign w_rs2_s  = rs2_i;

  always_comb begin
    w_alu = '0;
    case (op_i)
      OP_ADD:  w_alu = rs1_i + rs2_i;
      OP_SUB:  w_alu = rs1_i - rs2_i;
      OP_AND:  w_alu = rs1_i & rs2_i;
      OP_OR:   w_alu = rs1_i | rs2_i;
      OP_XOR:  w_alu = rs1_i ^ rs2_i;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, (w_rs1_s < w_rs2_s)};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (rs1_i < rs2_i)};
      default: w_alu = '0;
    endcase
    if (w_early) begin
      if (w_is_mul)                                  w_alu = '0;
      else if ((op_i == OP_DIV) || (op_i == OP_DIVU)) w_alu = '1;
      else                                           w_alu = rs1_i;
    end
  end

  // Multiply step: r_acc = {partial high, remaining multiplier bits}.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
  // Divide step: r_acc = {partial remainder, dividend/quotient bits}.
  assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff    = w_rem_sh - {1'b0, r_opnd};
  assign w_div_nxt = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                  : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      OP_MUL:            w_fix_res = r_acc[XLEN-1:0];
      OP_MULH:           w_fix_res = cond_neg_hi(r_neg_q, r_acc);
      OP_MULHU:          w_fix_res = r_acc[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:   w_fix_res = r_dz ? '1 : cond_neg(r_neg_q, r_acc[XLEN-1:0]);
      OP_REM, OP_REMU:   w_fix_res = cond_neg(r_neg_r, r_acc[2*XLEN-1:XLEN]);
      default:           w_fix_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:       if (w_go_mdu) w_state_nxt = w_is_mul ? S_MUL : S_DIV;
        S_MUL, S_DIV: if (r_cnt == '0) w_state_nxt = S_FIX;
        S_FIX:        if (w_fix_load) w_state_nxt = S_IDLE;
        default:      w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_go_mdu)
        r_cnt <= CNT_W'(XLEN - 1);
      else if (((r_state == S_MUL) || (r_state == S_DIV)) && (r_cnt != '0))
        r_cnt <= r_cnt - CNT_W'(1);
      if (flush_i)
        r_shadow <= SH_W'(FLUSH_SHADOW);
      else if (r_shadow != '0)
        r_shadow <= r_shadow - SH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_go_mdu) begin
      r_op    <= op_i;
      r_rd_v  <= rd_v_i;
      r_adr   <= rd_adr_i;
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
      r_dz    <= (rs2_i == '0);
      r_opnd  <= w_is_mul ? w_mag1 : w_mag2;
      r_acc   <= {{XLEN{1'b0}}, (w_is_mul ? w_mag2 : w_mag1)};
    end else if (r_state == S_MUL) begin
      r_acc <= w_mul_nxt;
    end else if (r_state == S_DIV) begin
      r_acc <= w_div_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_v    <= 1'b0;
      r_out_data <= '0;
      r_out_rd_v <= 1'b0;
      r_out_adr  <= '0;
    end else if (flush_i) begin
      r_out_v <= 1'b0;
    end else if (w_go_alu) begin
      r_out_v    <= 1'b1;
      r_out_data <= w_alu;
      r_out_rd_v <= rd_v_i;
      r_out_adr  <= rd_adr_i;
    end else if (w_fix_load) begin
      r_out_v    <= 1'b1;
      r_out_data <= w_fix_res;
      r_out_rd_v <= r_rd_v;
      r_out_adr  <= r_adr;
    end else if (r_out_v && out_rdy_i) begin
      r_out_v    <= 1'b0;
      r_out_data <= '0;
      r_out_rd_v <= 1'b0;
      r_out_adr  <= '0;
    end
  end

  assign out_v_q_o    = r_out_v;
  assign out_data_q_o = r_out_data;
  assign out_rd_v_q_o = r_out_rd_v;
  assign out_adr_q_o  = r_out_adr;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_exe_mdu_stage.sv
// Scoreboard bench for exe_mdu_stage: directed issues push expected results, a monitor pops on output handshakes.
module tb_exe_mdu_stage;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam int FLUSH_SHADOW = 2;
  localparam int MDU_LAT = XLEN + 2;
`ifdef EXE_MDU_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = MDU_LAT;
`endif

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4, SLT = 4'd5;
  localparam logic [3:0] SLTU = 4'd6, MUL = 4'd7, MULH = 4'd8, MULHU = 4'd9, DIV = 4'd10;
  localparam logic [3:0] DIVU = 4'd11, REM = 4'd12, REMU = 4'd13, RSV = 4'd14;

  logic             clk, reset_n, in_v_i, in_rdy_o, rd_v_i, flush_i;
  logic [3:0]       op_i;
  logic [XLEN-1:0]  rs1_i, rs2_i, out_data_q_o;
  logic [REG_W-1:0] rd_adr_i, out_adr_q_o;
  logic             out_v_q_o, out_rdy_i, out_rd_v_q_o, busy_o;

  exe_mdu_stage #(.XLEN(XLEN), .REG_W(REG_W), .FLUSH_SHADOW(FLUSH_SHADOW)) dut (
    .clk(clk), .reset_n(reset_n), .in_v_i(in_v_i), .in_rdy_o(in_rdy_o), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_v_i(rd_v_i), .rd_adr_i(rd_adr_i), .flush_i(flush_i),
    .out_v_q_o(out_v_q_o), .out_rdy_i(out_rdy_i), .out_data_q_o(out_data_q_o),
    .out_rd_v_q_o(out_rd_v_q_o), .out_adr_q_o(out_adr_q_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    logic [37:0] val;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] adr, input bit push, input logic [31:0] expd, input int lat,
                       output int waits);
    exp_t e;
    in_v_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_adr_i = adr; rd_v_i = (adr != 0);
    waits = 0;
    @(negedge clk);
    while (!in_rdy_o && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_rdy_o) begin
      chk({nm, "_accept_timeout"}, 64'd0, 64'd1);
    end else if (push) begin
      e.nm = nm; e.val = {(adr != 0), adr, expd}; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_v_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: record the first cycle a result is shown, compare when it is taken.
  bit   seen = 1'b0;
  int   first = 0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset_n) begin
      seen = 1'b0;
    end else begin
      if (out_v_q_o && !seen) begin
        seen = 1'b1;
        first = cyc;
      end
      if (out_v_q_o && out_rdy_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", {26'd0, out_rd_v_q_o, out_adr_q_o, out_data_q_o}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk(e.nm, {26'd0, out_rd_v_q_o, out_adr_q_o, out_data_q_o}, {26'd0, e.val});
          chk({e.nm, "_cycle"}, 64'(first), 64'(e.cyc));
        end
        seen = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 30000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit ok;
    reset_n = 1'b0; in_v_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
    rd_v_i = 1'b0; rd_adr_i = '0; flush_i = 1'b0; out_rdy_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_v", 64'(out_v_q_o), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_out_fields", {26'd0, out_rd_v_q_o, out_adr_q_o, out_data_q_o}, 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    issue("add_wrap", ADD, 32'hFFFF_FFFF, 32'd1, 5'd3, 1, 32'h0000_0000, 1, w);
    issue("sub",      SUB, 32'd5, 32'd7, 5'd4, 1, 32'hFFFF_FFFE, 1, w);
    issue("and",      AND_, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd5, 1, 32'h00F0_1234, 1, w);
    issue("or",       OR_, 32'hA000_0001, 32'h0500_0010, 5'd6, 1, 32'hA500_0011, 1, w);
    issue("xor",      XOR_, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd7, 1, 32'hF0F0_0F0F, 1, w);
    issue("slt",      SLT, 32'hFFFF_FFFF, 32'd1, 5'd8, 1, 32'd1, 1, w);
    issue("sltu",     SLTU, 32'hFFFF_FFFF, 32'd1, 5'd9, 1, 32'd0, 1, w);
    issue("reserved", RSV, 32'd12, 32'd34, 5'd0, 1, 32'd0, 1, w);
    drain();

    issue("mulh_neg", MULH, 32'h8000_0000, 32'd2, 5'd10, 1, 32'hFFFF_FFFF, MDU_LAT, w);
    ok = 1'b1;
    repeat (XLEN + 1) begin
      @(negedge clk);
      if (!(busy_o && !in_rdy_o)) ok = 1'b0;
    end
    chk("mulh_busy_window", 64'(ok), 64'd1);
    @(posedge clk); #1;
    chk("mulh_idle_after", 64'(busy_o), 64'd0);
    drain();

    issue("mul_lo",  MUL, 32'd3, 32'hFFFF_FFFB, 5'd11, 1, 32'hFFFF_FFF1, MDU_LAT, w);
    issue("mulhu",   MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1, 32'hFFFF_FFFE, MDU_LAT, w);
    issue("mulh_pp", MULH, 32'h4000_0000, 32'h0000_0010, 5'd13, 1, 32'h0000_0004, MDU_LAT, w);
    issue("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 5'd14, 1, 32'hFFFF_FFFD, MDU_LAT, w);
    issue("rem_neg", REM, 32'hFFFF_FFF9, 32'd2, 5'd15, 1, 32'hFFFF_FFFF, MDU_LAT, w);
    issue("divu",    DIVU, 32'd100, 32'd7, 5'd16, 1, 32'd14, MDU_LAT, w);
    issue("remu",    REMU, 32'd100, 32'd7, 5'd17, 1, 32'd2, MDU_LAT, w);
    issue("div_by0", DIV, 32'd7, 32'd0, 5'd18, 1, 32'hFFFF_FFFF, EARLY_LAT, w);
    issue("rem_by0", REM, 32'd7, 32'd0, 5'd19, 1, 32'd7, EARLY_LAT, w);
    issue("divu_by0", DIVU, 32'h8000_0001, 32'd0, 5'd20, 1, 32'hFFFF_FFFF, EARLY_LAT, w);
    issue("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 1, 32'h8000_0000, MDU_LAT, w);
    issue("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 1, 32'd0, MDU_LAT, w);
    issue("mul_zero", MUL, 32'd0, 32'h0000_1234, 5'd23, 1, 32'd0, EARLY_LAT, w);
    drain();

    out_rdy_i = 1'b0;
    issue("sub_bp", SUB, 32'd5, 32'd3, 5'd24, 1, 32'd2, 1, w);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(out_v_q_o && out_data_q_o == 32'd2 && out_adr_q_o == 5'd24 && out_rd_v_q_o && !in_rdy_o)) ok = 1'b0;
    end
    chk("bp_hold_stable", 64'(ok), 64'd1);
    @(posedge clk); #1;
    out_rdy_i = 1'b1;
    issue("add_after_bp", ADD, 32'd40, 32'd2, 5'd25, 1, 32'd42, 1, w);
    chk("bp_same_cycle_accept_waits", 64'(w), 64'd0);
    drain();

    issue("divu_flushed", DIVU, 32'd1000, 32'd7, 5'd26, 0, 32'd0, 0, w);
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    chk("flush_in_rdy_low", 64'(in_rdy_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_fsm_idle", 64'(busy_o), 64'd0);
    chk("flush_out_v_low", 64'(out_v_q_o), 64'd0);
    issue("shadow_mul", MUL, 32'd3, 32'd4, 5'd27, 0, 32'd0, 0, w);
    chk("shadow1_handshake_waits", 64'(w), 64'd0);
    issue("shadow_add", ADD, 32'd1, 32'd1, 5'd28, 0, 32'd0, 0, w);
    chk("shadow2_handshake_waits", 64'(w), 64'd0);
    chk("shadow_no_fsm_entry", 64'(busy_o), 64'd0);
    chk("shadow_no_result", 64'(out_v_q_o), 64'd0);
    issue("post_shadow_add", ADD, 32'd100, 32'd23, 5'd29, 1, 32'd123, 1, w);
    drain();

    issue("div_reset", DIV, 32'd1000, 32'd3, 5'd30, 0, 32'd0, 0, w);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midop_rst_busy", 64'(busy_o), 64'd0);
    chk("midop_rst_out_v", 64'(out_v_q_o), 64'd0);
    chk("midop_rst_in_rdy", 64'(in_rdy_o), 64'd1);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    issue("add_after_rst", ADD, 32'd10, 32'd20, 5'd31, 1, 32'd30, 1, w);
    repeat (XLEN + 8) @(posedge clk);
    #1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
